arm_hazard_scoreboard: RTL and testbench
========================================

// Module: arm_hazard_scoreboard
// PURPOSE
//   Parametrised hazard-detection and forwarding unit for the Arm pipeline. It replaces the fixed EXE/MEM compare logic.
//   - Tracks every in-flight instruction from EXE through WB in an internal shift pipeline of STAGES entries.
//   - Produces the IF/ID stall, and the EXE operand-forwarding selects for any pipeline depth and memory latency.
//   - Sits between IdStage outputs and the IfStage/IfReg freeze inputs and the ExeStage operand muxes.
// PARAMETERS
//   REG_ADDR_W  4  register-file address width
//   STAGES      3  tracked stages after ID (entry 1 = EXE, entry STAGES = WB); must be >= MEM_LAT+2
//   MEM_LAT     1  cycles after EXE before load data can be forwarded (load forwardable from entry MEM_LAT+2)
//   SEL_W       $clog2(STAGES)  width of forwarding selects (derived, do not override)
// PORTS
//   clk                input   1           rising-edge clock
//   rst                input   1           asynchronous, active-high reset
//   enable_forwarding  input   1           1: forward + load-use stall only; 0: stall on every RAW
//   mem_freeze         input   1           whole pipeline frozen this cycle (variable-latency memory)
//   branch_taken       input   1           branch resolved in EXE; instruction now in ID is discarded
//   id_valid           input   1           ID holds a real instruction
//   id_wb_en           input   1           ID instruction writes the register file
//   id_mem_read        input   1           ID instruction is a load
//   id_dest            input   REG_ADDR_W  ID destination register
//   id_src1            input   REG_ADDR_W  ID source 1 (Rn)
//   id_src2            input   REG_ADDR_W  ID source 2 (Rm / Rd for store)
//   id_two_src         input   1           src2 is a real operand
//   stall              output  1           freeze PC/IfReg and insert bubble into EXE
//   sel_src1           output  SEL_W       EXE Rn select: 0 = ID/EX value, j = forward from entry j+1
//   sel_src2           output  SEL_W       EXE Rm select, same encoding
//   pending_count      output  SEL_W+1     number of valid writing entries in flight
// BEHAVIOUR
//   Entry contents: {valid, wb_en, is_load, dest, src1, src2}. rst clears every valid bit asynchronously.
//   Reset values: stall=0, sel_src1=sel_src2=0, pending_count=0.
//   Match(e, r): e.valid & e.wb_en & e.dest==r. Entries with wb_en=0 or valid=0 never match.
//   raw1 = Match(entry k, id_src1); raw2 = id_two_src & Match(entry k, id_src2). ID fields are ignored when id_valid=0.
//   Stall condition:
//     - fwd off: raw1|raw2 for any k in 1..STAGES-1. The register file writes before it reads, so WB is exempt.
//     - fwd on: raw1|raw2 for any k in 1..MEM_LAT where entry k is_load.
//     - stall = id_valid & cond & ~branch_taken. It is combinational and branch_taken masks it.
//   Shift on posedge clk, only when mem_freeze=0:
//     - entry k <= entry k-1 for k=2..STAGES.
//     - entry 1 <= ID fields if (id_valid & ~stall & ~branch_taken), else a bubble (valid=0).
//   mem_freeze=1: all entries hold; stall and selects are recomputed from the held state, so they are unchanged.
//   Forward select for the EXE operand (entry 1 src1/src2):
//     - Take the smallest k in 2..STAGES with Match(entry k, src) and (~is_load | k >= MEM_LAT+2); sel = k-1.
//     - No such k gives sel = 0. The youngest producer wins.
//     - Entry 1 invalid, or enable_forwarding=0: sel = 0. Selects are combinational from registered state.
//   A load matching at k <= MEM_LAT+1 while its consumer sits in EXE cannot occur, because the stall rule prevents it.
//   The bench asserts this never happens.
//   pending_count = popcount(valid & wb_en) over entries 1..STAGES.
//   Latency: stall is same-cycle. Sels are valid in the cycle the consumer occupies EXE.
//   rst mid-operation drops all in-flight entries immediately.
// TESTING
//   Fwd on: ADD r1 issued, next cycle SUB r3,r1,r2 -> no stall; SUB in EXE: sel_src1=1; sel_src2=0.
//   Fwd on: LDR r2 then ADD r4,r2,r5 -> stall=1 for exactly 1 cycle; ADD in EXE has sel_src1=2; pending_count peaks at 2.
//   Fwd off: ADD r1 then ORR r6,r1,r1 -> stall for 2 cycles; ORR in EXE has sel_src1=sel_src2=0.
//   MOV r7 in MEM and MOV r7 in WB, consumer of r7 in EXE -> sel_src1=1 (youngest). Same case with r7 only in WB -> sel=2.
//   Fwd on, load-use stall pending, raise branch_taken -> stall=0, entry 1 becomes bubble, pending_count unchanged by ID.
//   mem_freeze=1 for 3 cycles mid-sequence -> entries, stall, sels, count constant. Then rst asserted -> all outputs 0 same cycle.

Source files
------------

// File: rtl/arm_hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight writers from EXE to WB, raises the IF/ID stall
// and picks the EXE operand forwarding source for any pipeline depth and load latency.
module arm_hazard_scoreboard #(
    parameter int  REG_ADDR_W = 4,
    parameter int  STAGES     = 3,
    parameter int  MEM_LAT    = 1,
    localparam int SEL_W      = $clog2(STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_forwarding,
    input  logic                  mem_freeze,
    input  logic                  branch_taken,
    input  logic                  id_valid,
    input  logic                  id_wb_en,
    input  logic                  id_mem_read,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_two_src,
    output logic                  stall,
    output logic [SEL_W-1:0]      sel_src1,
    output logic [SEL_W-1:0]      sel_src2,
    output logic [SEL_W:0]        pending_count
);

    // Entry 1 is EXE, entry STAGES is WB; only the EXE entry's sources are ever consulted.
    logic                  ent_vld  [1:STAGES];
    logic                  ent_wb   [1:STAGES];
    logic                  ent_ld   [1:STAGES];
    logic [REG_ADDR_W-1:0] ent_dest [1:STAGES];
    logic [REG_ADDR_W-1:0] exe_src1;
    logic [REG_ADDR_W-1:0] exe_src2;

    logic                  hit;
    logic                  accept;
    logic [SEL_W-1:0]      sel_a;
    logic [SEL_W-1:0]      sel_b;
    logic [SEL_W:0]        cnt;

    // WB is exempt from the stall scan because the register file writes before it reads.
    always_comb begin
        hit = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            if (ent_vld[k] && ent_wb[k] &&
                (ent_dest[k] == id_src1 || (id_two_src && ent_dest[k] == id_src2)) &&
                (!enable_forwarding || (k <= MEM_LAT && ent_ld[k])))
                hit = 1'b1;
        end
    end

    assign stall  = id_valid && hit && !branch_taken;
    assign accept = id_valid && !stall && !branch_taken;

    // Scan oldest to youngest so the youngest eligible producer is assigned last and wins.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        if (ent_vld[1] && enable_forwarding) begin
            for (int k = STAGES; k >= 2; k--) begin
                if (ent_vld[k] && ent_wb[k] && (!ent_ld[k] || k >= MEM_LAT + 2)) begin
                    if (ent_dest[k] == exe_src1)
                        sel_a = SEL_W'(k - 1);
                    if (ent_dest[k] == exe_src2)
                        sel_b = SEL_W'(k - 1);
                end
            end
        end
    end

    assign sel_src1 = sel_a;
    assign sel_src2 = sel_b;

    always_comb begin
        cnt = '0;
        for (int k = 1; k <= STAGES; k++)
            cnt = cnt + {{SEL_W{1'b0}}, ent_vld[k] & ent_wb[k]};
    end

    assign pending_count = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= STAGES; k++)
                ent_vld[k] <= 1'b0;
        end else if (!mem_freeze) begin
            ent_vld[1] <= accept;
            for (int k = 2; k <= STAGES; k++)
                ent_vld[k] <= ent_vld[k-1];
        end
    end

    // Payload is don't-care whenever the matching valid bit is clear, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!mem_freeze) begin
            ent_wb[1]   <= id_wb_en;
            ent_ld[1]   <= id_mem_read;
            ent_dest[1] <= id_dest;
            exe_src1    <= id_src1;
            exe_src2    <= id_src2;
            for (int k = 2; k <= STAGES; k++) begin
                ent_wb[k]   <= ent_wb[k-1];
                ent_ld[k]   <= ent_ld[k-1];
                ent_dest[k] <= ent_dest[k-1];
            end
        end
    end

endmodule

// File: tb/tb_arm_hazard_scoreboard.sv
// Bench for arm_hazard_scoreboard: directed pipeline scenarios plus random traffic,
// all checked against an instruction-level reference model of the pipeline.
module tb_arm_hazard_scoreboard;
    localparam int RW = 4;
    localparam int ST = 3;
    localparam int ML = 1;
    localparam int SW = $clog2(ST);

    logic          clk = 1'b0;
    logic          rst, enable_forwarding, mem_freeze, branch_taken;
    logic          id_valid, id_wb_en, id_mem_read, id_two_src;
    logic [RW-1:0] id_dest, id_src1, id_src2;
    logic          stall;
    logic [SW-1:0] sel_src1, sel_src2;
    logic [SW:0]   pending_count;

    arm_hazard_scoreboard #(.REG_ADDR_W(RW), .STAGES(ST), .MEM_LAT(ML)) dut (
        .clk(clk), .rst(rst), .enable_forwarding(enable_forwarding), .mem_freeze(mem_freeze),
        .branch_taken(branch_taken), .id_valid(id_valid), .id_wb_en(id_wb_en),
        .id_mem_read(id_mem_read), .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .stall(stall), .sel_src1(sel_src1), .sel_src2(sel_src2),
        .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one slot per instruction in flight, slot 1 = EXE, slot ST = WB.
    typedef struct {
        bit          v, wb, ld, two;
        bit [RW-1:0] d, s1, s2;
    } instr_t;
    instr_t pipe [1:ST];

    function automatic bit writes(int k, bit [RW-1:0] r);
        return pipe[k].v && pipe[k].wb && pipe[k].d == r;
    endfunction

    function automatic bit exp_stall();
        if (!id_valid || branch_taken) return 1'b0;
        for (int k = 1; k < ST; k++)
            if (writes(k, id_src1) || (id_two_src && writes(k, id_src2)))
                if (!enable_forwarding || (k <= ML && pipe[k].ld)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_sel(bit [RW-1:0] r);
        if (!pipe[1].v || !enable_forwarding) return 0;
        for (int k = 2; k <= ST; k++)
            if (writes(k, r) && (!pipe[k].ld || k >= ML + 2)) return k - 1;
        return 0;
    endfunction

    function automatic int exp_count();
        int n = 0;
        for (int k = 1; k <= ST; k++) n += (pipe[k].v && pipe[k].wb) ? 1 : 0;
        return n;
    endfunction

    function automatic bit load_use_escaped();
        if (!pipe[1].v) return 1'b0;
        for (int k = 2; k <= ML + 1; k++)
            if (pipe[k].ld && (writes(k, pipe[1].s1) || (pipe[1].two && writes(k, pipe[1].s2))))
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_id(input bit v, input bit wb, input bit ld, input int d,
                          input int s1, input int s2, input bit two);
        id_valid = v; id_wb_en = wb; id_mem_read = ld; id_two_src = two;
        id_dest = RW'(d); id_src1 = RW'(s1); id_src2 = RW'(s2);
    endtask

    task automatic nop();
        set_id(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    // Compare all outputs against the model, then advance one clock and update the model.
    task automatic step();
        instr_t nw;
        bit     acc;
        #1;
        if (rst)
            for (int k = 1; k <= ST; k++) pipe[k].v = 1'b0;
        check("stall", 32'(stall), 32'(exp_stall()));
        check("sel_src1", 32'(sel_src1), 32'(exp_sel(pipe[1].s1)));
        check("sel_src2", 32'(sel_src2), 32'(exp_sel(pipe[1].s2)));
        check("pending_count", 32'(pending_count), 32'(exp_count()));
        check("load_use_escape", 32'(load_use_escaped()), 32'd0);
        acc = id_valid && !exp_stall() && !branch_taken;
        nw.v = acc; nw.wb = id_wb_en; nw.ld = id_mem_read; nw.two = id_two_src;
        nw.d = id_dest; nw.s1 = id_src1; nw.s2 = id_src2;
        @(posedge clk);
        if (!rst && !mem_freeze) begin
            for (int k = ST; k >= 2; k--) pipe[k] = pipe[k-1];
            pipe[1] = nw;
        end
        #1;
    endtask

    task automatic drain();
        nop();
        for (int i = 0; i < ST; i++) step();
    endtask

    initial begin
        for (int k = 1; k <= ST; k++) pipe[k] = '{default: 0};
        rst = 1'b1; enable_forwarding = 1'b1; mem_freeze = 1'b0; branch_taken = 1'b0;
        nop();
        #1;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_sel1", 32'(sel_src1), 32'd0);
        check("reset_sel2", 32'(sel_src2), 32'd0);
        check("reset_count", 32'(pending_count), 32'd0);
        step();
        rst = 1'b0;

        // ADD r1 then SUB r3,r1,r2 with forwarding
        set_id(1, 1, 0, 1, 0, 0, 0); step();
        set_id(1, 1, 0, 3, 1, 2, 1); #1; check("add_sub_stall", 32'(stall), 32'd0); step();
        nop(); #1;
        check("add_sub_sel1", 32'(sel_src1), 32'd1);
        check("add_sub_sel2", 32'(sel_src2), 32'd0);
        drain();

        // LDR r2 then ADD r4,r2,r5: one-cycle load-use stall
        set_id(1, 1, 1, 2, 0, 0, 0); step();
        set_id(1, 1, 0, 4, 2, 5, 1); #1; check("ldr_stall_c1", 32'(stall), 32'd1); step();
        #1; check("ldr_stall_c2", 32'(stall), 32'd0); step();
        nop(); #1;
        check("ldr_add_sel1", 32'(sel_src1), 32'd2);
        check("ldr_add_count", 32'(pending_count), 32'd2);
        drain();

        // Forwarding off: ADD r1 then ORR r6,r1,r1 stalls two cycles
        enable_forwarding = 1'b0;
        set_id(1, 1, 0, 1, 0, 0, 0); step();
        set_id(1, 1, 0, 6, 1, 1, 1); #1; check("nofwd_stall_c1", 32'(stall), 32'd1); step();
        #1; check("nofwd_stall_c2", 32'(stall), 32'd1); step();
        #1; check("nofwd_stall_c3", 32'(stall), 32'd0); step();
        nop(); #1;
        check("nofwd_sel1", 32'(sel_src1), 32'd0);
        check("nofwd_sel2", 32'(sel_src2), 32'd0);
        drain();
        enable_forwarding = 1'b1;

        // Two producers of r7: youngest wins; then r7 only in WB
        set_id(1, 1, 0, 7, 0, 0, 0); step();
        step();
        set_id(1, 1, 0, 8, 7, 0, 0); step();
        nop(); #1; check("youngest_sel1", 32'(sel_src1), 32'd1);
        drain();
        set_id(1, 1, 0, 7, 0, 0, 0); step();
        nop(); step();
        set_id(1, 1, 0, 8, 7, 0, 0); step();
        nop(); #1; check("wb_only_sel1", 32'(sel_src1), 32'd2);
        drain();

        // Branch masks a pending load-use stall
        set_id(1, 1, 1, 2, 0, 0, 0); step();
        set_id(1, 1, 0, 4, 2, 5, 1); branch_taken = 1'b1;
        #1; check("branch_stall", 32'(stall), 32'd0); step();
        branch_taken = 1'b0; nop(); #1;
        check("branch_count", 32'(pending_count), 32'd1);
        drain();

        // Freeze for three cycles, then async reset mid-operation
        set_id(1, 1, 0, 1, 0, 0, 0); step();
        set_id(1, 1, 0, 3, 1, 2, 1); step();
        set_id(1, 1, 1, 5, 0, 0, 0); step();
        set_id(1, 1, 0, 9, 5, 0, 0); mem_freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("freeze_stall", 32'(stall), 32'd1);
            check("freeze_count", 32'(pending_count), 32'd3);
            step();
        end
        mem_freeze = 1'b0;
        #2; rst = 1'b1; #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_sel1", 32'(sel_src1), 32'd0);
        check("rst_sel2", 32'(sel_src2), 32'd0);
        check("rst_count", 32'(pending_count), 32'd0);
        step();
        rst = 1'b0;

        // Random traffic over a small register set to provoke frequent hazards
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) enable_forwarding = 1'($urandom_range(0, 1));
            mem_freeze   = ($urandom_range(0, 99) < 15);
            branch_taken = ($urandom_range(0, 99) < 10);
            rst          = ($urandom_range(0, 99) < 2);
            set_id(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 2) == 0), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            step();
        end
        rst = 1'b0; mem_freeze = 1'b0; branch_taken = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
